// File: rtl/mdu_mul_pkg.sv
// mdu_mul_pkg: shared state encoding, iteration count and carry helper for the multiplier
package mdu_mul_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MUL   = 3'd1;
  localparam logic [2:0] FIX_A = 3'd2;
  localparam logic [2:0] FIX_B = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int MUL_ITERS = 32;
  localparam logic [4:0] LAST_ITER = 5'(MUL_ITERS - 1);

  // cla32 has no carry output, so the top bit's carry is rebuilt from the operand and sum MSBs
  function automatic logic add_cout(input logic x, input logic y, input logic s);
    return x & y | (x | y) & ~s;
  endfunction

endpackage

// File: rtl/mdu_mul_cla32.sv
// cla32: 32-bit carry-lookahead adder built from 4-bit lookahead groups
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s
);

  logic [7:0] cg;

  assign cg[0] = ci;

  for (genvar k = 0; k < 8; k++) begin : grp
    logic [3:0] g, p, c;
    assign g = a[4*k +: 4] & b[4*k +: 4];
    assign p = a[4*k +: 4] ^ b[4*k +: 4];
    assign c[0] = cg[k];
    assign c[1] = g[0] | p[0] & c[0];
    assign c[2] = g[1] | p[1] & g[0] | p[1] & p[0] & c[0];
    assign c[3] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & c[0];
    assign s[4*k +: 4] = p ^ c;
    if (k < 7) begin : nx
      logic gg, pg;
      assign gg = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0];
      assign pg = &p;
      assign cg[k+1] = gg | pg & cg[k];
    end
  end

endmodule

// File: rtl/mdu_mul.sv
// mdu_mul: sequential 32x32->64 shift-add multiplier holding HI/LO, one cla32 addition per cycle
module mdu_mul
  import mdu_mul_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        whi,
  input  logic        wlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [2:0]  state, state_nx;
  logic [31:0] ra, rb, acc_hi, acc_lo, y, sum;
  logic        rs, ci, cout, idle_or_done, last;
  logic [4:0]  cnt;

  assign idle_or_done = state == IDLE || state == DONE;
  assign last = cnt == LAST_ITER;

  // Second operand: partial product in MUL, inverted sign corrections (with ci=1) in the fix-up states
  always_comb begin
    y  = state == MUL ? (acc_lo[0] ? ra : '0) :
         state == FIX_A ? ~(ra[31] ? rb : '0) : ~(rb[31] ? ra : '0);
    ci = state == FIX_A || state == FIX_B;
  end

  cla32 u_cla (.a(acc_hi), .b(y), .ci(ci), .s(sum));

  assign cout = add_cout(acc_hi[31], y[31], sum[31]);

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else state <= state_nx;
  end

  // Next-state: signed results take two extra correction cycles before DONE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? MUL : IDLE;
      MUL:     state_nx = last ? (rs ? FIX_A : DONE) : MUL;
      FIX_A:   state_nx = FIX_B;
      FIX_B:   state_nx = DONE;
      DONE:    state_nx = start ? MUL : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = state == MUL || state == FIX_A || state == FIX_B;
    done = state == DONE;
  end

  // Datapath: operand capture, shift-add iterations, sign fix-up and HI/LO writes
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ra     <= '0;
      rb     <= '0;
      rs     <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (idle_or_done && start) begin
        ra     <= a;
        rb     <= b;
        rs     <= sign;
        acc_hi <= '0;
        acc_lo <= b;
        cnt    <= '0;
      end
      if (idle_or_done && whi) hi <= wdata;
      if (idle_or_done && wlo) lo <= wdata;
      if (state == MUL) begin
        {acc_hi, acc_lo} <= {cout, sum, acc_lo[31:1]};
        cnt <= cnt + 5'd1;
        if (last && !rs) {hi, lo} <= {cout, sum, acc_lo[31:1]};
      end
      if (state == FIX_A) acc_hi <= sum;
      if (state == FIX_B) begin
        hi <= sum;
        lo <= acc_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_mul.sv
// tb_mdu_mul: vector table, random and corner-sequence checks of mdu_mul against a 64-bit arithmetic model
module tb_mdu_mul;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        whi = 1'b0;
  logic        wlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mdu_mul dut (
    .clk(clk), .clrn(clrn), .start(start), .sign(sign), .a(a), .b(b),
    .whi(whi), .wlo(wlo), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t tv[8];

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] ex, ey;
    ex = s ? {{32{x[31]}}, x} : {32'b0, x};
    ey = s ? {{32{y[31]}}, y} : {32'b0, y};
    return ex * ey;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (clrn && busy && done) begin
      failures++;
      $display("FAIL busy_done_overlap: busy=%b done=%b", busy, done);
    end
  end

  task automatic launch(input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    sign = s; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", {63'b0, busy}, 64'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1 n++;
      if (done) return;
    end
    chk("done_timeout", 64'(n), 64'd0);
  endtask

  int n;
  logic [31:0] hold_hi, hold_lo;
  logic [63:0] p;

  initial begin
    tv[0] = '{1'b0, 32'd7,        32'd6,        64'h00000000_0000002A};
    tv[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    tv[2] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
    tv[3] = '{1'b1, 32'hFFFFFFFF, 32'd2,        64'hFFFFFFFF_FFFFFFFE};
    tv[4] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    tv[5] = '{1'b0, 32'h80000000, 32'd2,        64'h00000001_00000000};
    tv[6] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
    tv[7] = '{1'b1, 32'd0,        32'hFFFFFFFF, 64'h0};

    #3;
    chk("reset_hi", {32'b0, hi}, 64'd0);
    chk("reset_lo", {32'b0, lo}, 64'd0);
    chk("reset_busy_done", {62'b0, busy, done}, 64'd0);
    @(negedge clk);
    clrn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      launch(tv[i].s, tv[i].a, tv[i].b);
      wait_done(n);
      chk($sformatf("vec%0d_latency", i), 64'(n), tv[i].s ? 64'd34 : 64'd32);
      chk($sformatf("vec%0d_hilo", i), {hi, lo}, tv[i].p);
      @(posedge clk);
      #1 chk($sformatf("vec%0d_done_pulse", i), {62'b0, busy, done}, 64'd0);
    end

    for (int i = 0; i < 20; i++) begin
      logic        s;
      logic [31:0] x, y;
      s = 1'($urandom_range(1));
      x = $urandom;
      y = $urandom;
      if (i < 4) x[31] = 1'b1;
      if (i < 2) y[31] = 1'b1;
      launch(s, x, y);
      wait_done(n);
      chk($sformatf("rand%0d_latency", i), 64'(n), s ? 64'd34 : 64'd32);
      chk($sformatf("rand%0d_hilo", i), {hi, lo}, ref_mul(s, x, y));
    end

    hold_hi = hi;
    hold_lo = lo;
    launch(1'b0, 32'd11, 32'd13);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'd99; b = 32'd99; whi = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 start = 1'b0; whi = 1'b0;
    chk("busy_whi_ignored", {hold_hi, hold_lo}, {hi, lo});
    chk("busy_mid_op", {63'b0, busy}, 64'd1);
    wait_done(n);
    chk("mid_start_latency", 64'(6 + n), 64'd32);
    chk("mid_start_result", {hi, lo}, 64'd143);

    launch(1'b1, 32'hFFFFFFFD, 32'd1000);
    chk("b2b_no_done", {63'b0, done}, 64'd0);
    wait_done(n);
    chk("b2b_latency", 64'(n), 64'd34);
    chk("b2b_result", {hi, lo}, ref_mul(1'b1, 32'hFFFFFFFD, 32'd1000));

    @(posedge clk);
    @(negedge clk);
    whi = 1'b1; wdata = 32'h12345678;
    @(posedge clk);
    #1 whi = 1'b0;
    chk("mthi", {hi, lo}, {32'h12345678, 32'hFFFFF448});
    @(negedge clk);
    wlo = 1'b1; wdata = 32'h9ABCDEF0;
    @(posedge clk);
    #1 wlo = 1'b0;
    chk("mtlo", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});
    repeat (3) @(posedge clk);
    #1 chk("hilo_hold", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});

    launch(1'b0, 32'h0000FFFF, 32'h0000FFFF);
    repeat (10) @(posedge clk);
    #3 clrn = 1'b0;
    #1;
    chk("async_reset_hilo", {hi, lo}, 64'd0);
    chk("async_reset_status", {62'b0, busy, done}, 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1 chk("post_reset_idle", {62'b0, busy, done}, 64'd0);
    launch(1'b0, 32'd3, 32'd5);
    wait_done(n);
    chk("post_reset_latency", 64'(n), 64'd32);
    chk("post_reset_result", {hi, lo}, 64'd15);

    p = ref_mul(1'b1, 32'h80000000, 32'h7FFFFFFF);
    launch(1'b1, 32'h80000000, 32'h7FFFFFFF);
    wait_done(n);
    chk("final_signed", {hi, lo}, p);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_mul.md
# mdu_mul

Sequential 32x32→64 multiplier for the pipelined CPU's multiply/divide unit, executing `mult`/`multu` and holding the architectural HI/LO registers. It sits directly upstream of the 32-bit carry-lookahead adder (`cla32`): it feeds that adder one partial-product addition per cycle and consumes its sum. It raises `busy` so the hazard unit stalls `mfhi`/`mflo`/`mult*`. It also services `mthi`/`mtlo` writes.

## Interface
- Parameters: none; datapath width is fixed at 32 to match `cla32`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `clrn` in 1: reset, asynchronous, active-low.
- `start` in 1: launch a multiply; sampled only in IDLE or DONE.
- `sign` in 1: 1 = `mult` (two's complement), 0 = `multu`; captured with `start`.
- `a` in 32: multiplicand; captured with `start`.
- `b` in 32: multiplier; captured with `start`.
- `whi`, `wlo` in 1: `mthi`/`mtlo` write strobes.
- `wdata` in 32: data for `whi`/`wlo`.
- `busy` out 1: high in MUL, FIX_A and FIX_B.
- `done` out 1: one-cycle pulse, high in DONE.
- `hi`, `lo` out 32: architectural HI/LO registers.

## Operation
- States: IDLE, MUL, FIX_A, FIX_B, DONE.
- IDLE/DONE with `start=1`:
  - Capture `a`, `b` and `sign` into `ra`, `rb` and `rs`.
  - Set `acc_hi=0`, `acc_lo=b` and `cnt=0`, then go to MUL.
- DONE with no `start`: go to IDLE.
- MUL, one iteration per cycle:
  - `sum = cla32(acc_hi, acc_lo[0] ? ra : 0, ci=0)`.
  - Carry-out is computed locally as `cout = x[31]&y[31] | (x[31]|y[31])&~sum[31]`, because `cla32` has no carry output.
  - `{acc_hi, acc_lo} <= {cout, sum, acc_lo[31:1]}` and `cnt <= cnt+1`.
  - After iteration 32 (`cnt==31`), `{acc_hi, acc_lo}` holds the unsigned product.
  - If `rs=0`: load `hi<=acc_hi_next` and `lo<=acc_lo_next`, then go to DONE.
  - If `rs=1`: go to FIX_A.
- FIX_A: `acc_hi <= cla32(acc_hi, ~(ra[31] ? rb : 0), ci=1)`, i.e. subtract `rb` when `ra` is negative. Then go to FIX_B.
- FIX_B: `hi <= cla32(acc_hi, ~(rb[31] ? ra : 0), ci=1)` and `lo <= acc_lo`. Then go to DONE.
- Exactly one `cla32` instance. Its operand muxes are selected by state. All arithmetic is mod 2^32 on `acc_hi`.
- `whi`/`wlo` in IDLE or DONE write `wdata` to `hi`/`lo` at that edge.
  - `whi`/`wlo` while `busy` are ignored; the pipeline is stalled then, so this never occurs legally.
  - If a write and `start` occur in the same cycle, both take effect; the multiply result overwrites HI/LO later.
- `start` while `busy` is ignored.
- `hi`/`lo` change only at the result edge or on `mthi`/`mtlo`. They hold between operations.

## Timing
- Reset (`clrn=0`, asynchronous, may occur mid-operation):
  - State goes to IDLE.
  - `busy=0`, `done=0`, `hi=0`, `lo=0`, `cnt=0`, `acc=0`.
  - Any operation in flight is discarded.
- Let E0 be the edge that samples `start`.
  - `busy=1` from E0 until the result edge.
  - Unsigned: result edge is E32; `done=1` in the following cycle. Latency is 32 cycles, 33 edges to IDLE.
  - Signed: result edge is E34; latency is 34 cycles.
- `done` and `busy` are never high together.
- Back-to-back operation: `start` asserted during the `done` cycle is accepted; `busy` rises with no idle gap.
- `mthi`/`mtlo` are visible on `hi`/`lo` one edge after the strobe.

## Structure
- Shared definitions file `mdu_defs`:
  - State encoding localparams: IDLE=0, MUL=1, FIX_A=2, FIX_B=3, DONE=4 (3 bits).
  - Iteration count constant `MUL_ITERS=32`.
- The only sub-module is the existing `cla32`. The carry-out logic and operand muxes are local combinational logic in `mdu_mul`.

## Test plan
- `multu` 7×6 → `done` 32 cycles after start; `hi=0x00000000`, `lo=0x0000002A`.
- `multu` 0xFFFFFFFF×0xFFFFFFFF → `hi=0xFFFFFFFE`, `lo=0x00000001`; exercises the local carry-out path.
- `mult` 0xFFFFFFFF×0xFFFFFFFF → `hi=0`, `lo=1` after 34 cycles. `mult` 0xFFFFFFFF×2 → `hi=0xFFFFFFFF`, `lo=0xFFFFFFFE`. `mult` 0x80000000×0x80000000 → `hi=0x40000000`, `lo=0`.
- `start` pulsed again mid-MUL with different operands → ignored; the original result is produced. A new `start` in the `done` cycle → accepted with no idle gap.
- `mthi` 0x12345678 and `mtlo` 0x9ABCDEF0 in IDLE → `hi`/`lo` update next edge. `whi` during `busy` → `hi` unchanged.
- `clrn` asserted at iteration 10 → outputs 0 immediately with state IDLE; a subsequent `multu` 3×5 → `lo=15`.
